// File: rtl/seadd_pkg.sv
// Shared types and constants for the serial adder and its operand serializer.
package seadd_pkg;

   localparam int SEADD_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLR   = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Counter width for a down-counter holding values up to width-1; never narrower than one bit.
   function automatic int CNT_W(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/seadd_piso.sv
// Parallel-in/serial-out shift register, LSB presented first on dout.
module seadd_piso
   import seadd_pkg::*;
#(
   parameter int WIDTH = SEADD_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] din,
   output logic             dout
);

   logic [WIDTH-1:0] sr;

   // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         sr <= '0;
      else if (load)
         sr <= din;
      else if (shift)
         sr <= {1'b0, sr[WIDTH-1:1]};
   end

   assign dout = sr[0];

endmodule

// File: rtl/seadd_tx.sv
// Operand serializer: accepts an operand pair, clears the serial adder, then shifts both operands out LSB-first.
module seadd_tx
   import seadd_pkg::*;
#(
   parameter int WIDTH      = SEADD_WIDTH,
   parameter int CLR_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             ser_clr,
   output logic             ser_a,
   output logic             ser_b,
   output logic             ser_valid,
   output logic             busy,
   output logic             done
);

   localparam int CW = CNT_W(WIDTH);
   localparam int KW = CNT_W(CLR_CYCLES);

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [KW-1:0]   clr_cnt, clr_cnt_n;
   logic            load, shift, accept;
   logic            a_bit, b_bit;
   logic            in_ready_n, ser_clr_n, ser_a_n, ser_b_n, ser_valid_n, busy_n, done_n;

   seadd_piso #(.WIDTH(WIDTH)) u_piso_a (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .shift (shift),
      .din   (op_a),
      .dout  (a_bit)
   );

   seadd_piso #(.WIDTH(WIDTH)) u_piso_b (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .shift (shift),
      .din   (op_b),
      .dout  (b_bit)
   );

   assign accept = in_valid & in_ready;

   // NOTE: every signal written here is defaulted first, so no path leaves one unassigned (no latch).
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      clr_cnt_n   = clr_cnt;
      load        = 1'b0;
      shift       = 1'b0;
      in_ready_n  = 1'b0;
      ser_clr_n   = 1'b0;
      ser_a_n     = 1'b0;
      ser_b_n     = 1'b0;
      ser_valid_n = 1'b0;
      busy_n      = 1'b0;
      done_n      = 1'b0;

      case (state)
         ST_IDLE, ST_DONE: begin
            if (accept) begin
               state_n   = ST_CLR;
               load      = 1'b1;
               cnt_n     = CW'(WIDTH - 1);
               clr_cnt_n = KW'(CLR_CYCLES - 1);
               ser_clr_n = 1'b1;
               busy_n    = 1'b1;
            end else begin
               state_n    = ST_IDLE;
               in_ready_n = 1'b1;
            end
         end

         ST_CLR: begin
            busy_n = 1'b1;
            if (clr_cnt == '0) begin
               // Bit 0 leaves the shift registers on the same edge that drops the clear.
               state_n     = ST_SHIFT;
               shift       = 1'b1;
               ser_a_n     = a_bit;
               ser_b_n     = b_bit;
               ser_valid_n = 1'b1;
            end else begin
               clr_cnt_n = clr_cnt - 1'b1;
               ser_clr_n = 1'b1;
            end
         end

         ST_SHIFT: begin
            if (cnt == '0) begin
               state_n    = ST_DONE;
               done_n     = 1'b1;
               in_ready_n = 1'b1;
            end else begin
               shift       = 1'b1;
               cnt_n       = cnt - 1'b1;
               ser_a_n     = a_bit;
               ser_b_n     = b_bit;
               ser_valid_n = 1'b1;
               busy_n      = 1'b1;
            end
         end

         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         clr_cnt   <= '0;
         in_ready  <= 1'b0;
         ser_clr   <= 1'b0;
         ser_a     <= 1'b0;
         ser_b     <= 1'b0;
         ser_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         clr_cnt   <= clr_cnt_n;
         in_ready  <= in_ready_n;
         ser_clr   <= ser_clr_n;
         ser_a     <= ser_a_n;
         ser_b     <= ser_b_n;
         ser_valid <= ser_valid_n;
         busy      <= busy_n;
         done      <= done_n;
      end
   end

endmodule

// File: tb/tb_seadd_tx.sv
// Scoreboard bench for seadd_tx at two parameter points (WIDTH=4/CLR=1 and WIDTH=8/CLR=2).
module tb_seadd_tx;

   typedef struct {
      int unsigned a;
      int unsigned b;
      int unsigned sum;
      int unsigned acc;
   } xfer_t;

   logic        clk = 1'b0;
   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : cfg
      localparam int W = (g == 0) ? 4 : 8;
      localparam int C = (g == 0) ? 1 : 2;
      localparam logic [31:0] MASK = (32'h1 << W) - 32'h1;

      logic         rst = 1'b1;
      logic         in_valid = 1'b0;
      logic [W-1:0] op_a = '0;
      logic [W-1:0] op_b = '0;
      logic         in_ready, ser_clr, ser_a, ser_b, ser_valid, busy, done;
      bit           fin = 1'b0;
      xfer_t        exp_q[$];
      int unsigned  last_acc = 0;

      seadd_tx #(.WIDTH(W), .CLR_CYCLES(C)) dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid),
         .in_ready  (in_ready),
         .op_a      (op_a),
         .op_b      (op_b),
         .ser_clr   (ser_clr),
         .ser_a     (ser_a),
         .ser_b     (ser_b),
         .ser_valid (ser_valid),
         .busy      (busy),
         .done      (done)
      );

      // Present a pair and hold it until accepted; returns on the negedge after the accept edge.
      task automatic offer(input logic [31:0] a, input logic [31:0] b);
         int    n;
         xfer_t x;
         in_valid = 1'b1;
         op_a     = a[W-1:0];
         op_b     = b[W-1:0];
         for (n = 0; n < 200; n++) begin
            if (in_ready) break;
            @(negedge clk);
         end
         check("accept_in_time", 32'(n < 200), 32'd1);
         if (n < 200) begin
            x.a   = a & MASK;
            x.b   = b & MASK;
            x.sum = (x.a + x.b) & MASK;
            x.acc = cyc + 1;
            last_acc = x.acc;
            exp_q.push_back(x);
         end
         @(negedge clk);
      endtask

      task automatic idle(input int n);
         in_valid = 1'b0;
         repeat (n) @(negedge clk);
      endtask

      // Driver
      initial begin
         int unsigned prev;
         #1 rst = 1'b0;
         #2 check("reset_outs", 32'({in_ready, ser_clr, ser_a, ser_b, ser_valid, busy, done}), 32'd0);
         @(negedge clk);
         @(negedge clk);
         rst = 1'b1;
         @(posedge clk);
         #1 check("ready_after_reset", 32'(in_ready), 32'd1);
         @(negedge clk);

         offer(32'h5, 32'h3);
         offer(32'hF, 32'h1);
         offer(32'hA5, 32'h3C);
         idle(W + C + 3);

         offer(32'h2, 32'h3);
         prev = last_acc;
         offer(32'h7, 32'h7);
         check("b2b_spacing", last_acc - prev, 32'(C + W + 1));
         idle(W + C + 3);

         // Abort after bit 1 of (5,3)
         offer(32'h5, 32'h3);
         in_valid = 1'b0;
         repeat (C + 1) @(negedge clk);
         #1 rst = 1'b0;
         #1 check("abort_outs", 32'({in_ready, ser_clr, ser_a, ser_b, ser_valid, busy, done}), 32'd0);
         @(negedge clk);
         @(negedge clk);
         check("abort_held", 32'({in_ready, ser_clr, ser_a, ser_b, ser_valid, busy, done}), 32'd0);
         rst = 1'b1;
         @(posedge clk);
         #1 check("ready_after_abort", 32'(in_ready), 32'd1);
         @(negedge clk);
         offer(32'h1, 32'h1);
         idle(W + C + 3);

         // in_valid pulsed with junk while shifting must be ignored
         offer(32'h9, 32'h6);
         in_valid = 1'b0;
         repeat (C + 1) @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            op_a     = W'($urandom);
            op_b     = W'($urandom);
            check("ready_low_shift", 32'(in_ready), 32'd0);
            @(negedge clk);
         end
         idle(W + C + 3);

         for (int i = 0; i < 25; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            if (gap != 0) idle(gap);
            offer($urandom, $urandom);
         end
         idle(W + C + 4);
         check("queue_drain", 32'(exp_q.size()), 32'd0);
         fin = 1'b1;
      end

      // Monitor: rebuilds each transfer from the serial outputs and compares to the scoreboard.
      bit          in_xfer = 1'b0;
      bit          have = 1'b0;
      int          clr_n = 0;
      int          nbits = 0;
      logic [31:0] ca = '0;
      logic [31:0] cb = '0;
      xfer_t       cur;

      always @(negedge clk) begin
         if (!rst) begin
            in_xfer = 1'b0;
            have    = 1'b0;
         end else begin
            check("clr_valid_excl", 32'(ser_clr & ser_valid), 32'd0);
            check("busy_match", 32'(busy), 32'(ser_clr | ser_valid));
            check("ready_busy_excl", 32'(in_ready & busy), 32'd0);
            if (!ser_valid) check("ser_zero_idle", 32'({ser_a, ser_b}), 32'd0);
            if (ser_clr && !in_xfer) begin
               in_xfer = 1'b1;
               clr_n   = 0;
               nbits   = 0;
               ca      = '0;
               cb      = '0;
               have    = (exp_q.size() != 0);
               check("expected_xfer", 32'(have), 32'd1);
               if (have) begin
                  cur = exp_q.pop_front();
                  check("clr_start_cyc", cyc, cur.acc);
               end
            end
            if (ser_clr) clr_n++;
            if (ser_valid) begin
               if (nbits < W) begin
                  ca[nbits] = ser_a;
                  cb[nbits] = ser_b;
               end
               nbits++;
            end
            if (done) begin
               check("done_in_xfer", 32'(in_xfer), 32'd1);
               if (in_xfer && have) begin
                  check("clr_len", 32'(clr_n), 32'(C));
                  check("nbits", 32'(nbits), 32'(W));
                  check("op_a_bits", ca, cur.a);
                  check("op_b_bits", cb, cur.b);
                  check("sum", (ca + cb) & MASK, cur.sum);
                  check("done_cyc", cyc - cur.acc, 32'(C + W));
                  check("ready_at_done", 32'(in_ready), 32'd1);
               end
               in_xfer = 1'b0;
               have    = 1'b0;
            end
         end
      end
   end

   initial begin
      int n;
      for (n = 0; n < 20000; n++) begin
         @(negedge clk);
         if (cfg[0].fin && cfg[1].fin) break;
      end
      check("finish_in_time", 32'(n < 20000), 32'd1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
